// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus bundle shared by the processor and its memory-mapped
// responders (d_mem, mmio_uart_tx).
//   Address   : byte address from the ALU result
//   WriteData : store data (register rt)
//   MemWrite  : store strobe, sampled on the clock edge
//   MemRead   : load strobe, qualifies ReadData
//   ReadData  : combinational load data from the responder
// master: the processor side.  slave: a responder such as the UART.
interface mmio_uart_tx_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Stores to TXDATA queue bytes in a small FIFO; the TX FSM serialises them
// LSB first. ReadData is zero whenever this block is not addressed so the
// top level can OR it with d_mem's ReadData.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : data-memory bus (slave side)
//   tx    : registered serial output, idle high
// Register window (16 bytes at BASE_ADDR, index = Address[3:2]):
//   0 TXDATA : write pushes WriteData[7:0]; reads 0
//   1 STATUS : {16'b0, count[15:8], 4'b0, overflow, empty, full, busy};
//              write with WriteData[3]=1 clears overflow
//   2,3      : reads 0, writes ignored
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic           clock,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           tx
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0] BIT_RELOAD = BCW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Bus decode
    logic       sel;
    logic [1:0] reg_idx;
    logic       wr_data;
    logic       wr_status;
    logic       unused_bits;

    assign sel         = (bus.Address[31:4] == BASE_ADDR[31:4]);
    assign reg_idx     = bus.Address[3:2];
    assign wr_data     = sel && bus.MemWrite && (reg_idx == 2'd0);
    assign wr_status   = sel && bus.MemWrite && (reg_idx == 2'd1);
    assign unused_bits = ^{bus.Address[1:0], bus.WriteData[31:8]};

    // FIFO state
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, push, pop;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // Full is taken from the registered count, so a same-cycle pop never
    // makes room for a push.
    assign push  = wr_data && !full;

    // TX state
    state_t         state_q, state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;

    assign tx = tx_q;

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.WriteData[7:0];
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q;
        if (wr_data && full) begin
            overflow_d = 1'b1;
        end else if (wr_status && bus.WriteData[3]) begin
            overflow_d = 1'b0;
        end
    end

    // TX FSM: next state and outputs
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem[rd_ptr_q];
                    tx_d      = 1'b0;
                    bit_cnt_d = BIT_RELOAD;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_cnt_q == '0) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    bit_cnt_d = BIT_RELOAD;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift register always presents the current bit at [0]
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // Loads are side-effect free and combinational
    always_comb begin
        bus.ReadData = '0;
        if (sel && bus.MemRead && (reg_idx == 2'd1)) begin
            bus.ReadData = {16'b0, 8'(count_q), 4'b0,
                            overflow_q, empty, full, (state_q != IDLE)};
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with CLKS_PER_BIT=4. Stimulus pushes the bytes it
// expects on the serial line into a queue; a separate serial receiver
// process decodes frames from tx and checks them against that queue.
module tb_mmio_uart_tx;
    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'hFFFF0000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic tx;

    always #5 clock = ~clock;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus),
        .tx   (tx)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    int         reset_edges = 0;

    always @(posedge clock) begin
        if (reset) reset_edges <= reset_edges + 1;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; the store is taken at the next edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.Address   = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        @(posedge clock);
        #1;
        bus.MemWrite  = 1'b0;
        $display("store addr=%h data=%h", a, d);
    endtask

    task automatic load(input logic [31:0] a, input logic rd, output logic [31:0] d);
        bus.Address = a;
        bus.MemRead = rd;
        #1;
        d = bus.ReadData;
        bus.MemRead = 1'b0;
        $display("load addr=%h rd=%0b data=%h", a, rd, d);
    endtask

    // Serial receiver / scoreboard checker
    initial begin
        logic [7:0] rx;
        logic       start_bit, stop_bit;
        int         rst_mark;
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                rst_mark = reset_edges;
                repeat (CPB / 2) @(negedge clock);
                start_bit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    rx[i] = tx;
                end
                repeat (CPB) @(negedge clock);
                stop_bit = tx;
                if (reset_edges == rst_mark) begin
                    $display("rx frame byte=%h", rx);
                    check32("rx_start_bit", {31'b0, start_bit}, 32'd0);
                    check32("rx_stop_bit", {31'b0, stop_bit}, 32'd1);
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL rx_unexpected: got %h expected no frame", rx);
                    end else begin
                        logic [7:0] exp;
                        exp = sb.pop_front();
                        if (rx !== exp) begin
                            failures++;
                            $display("FAIL rx_byte: got %h expected %h", rx, exp);
                        end
                    end
                end else begin
                    $display("rx frame aborted by reset");
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  a5;
        logic        exp_tx;
        int          errs, first_bad;

        bus.Address   = '0;
        bus.WriteData = '0;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clock);
        #1;
        check32("tx_in_reset", {31'b0, tx}, 32'd1);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check32("tx_idle", {31'b0, tx}, 32'd1);
        load(BASE + 32'd4, 1'b1, v);
        check32("status_idle", v, 32'h00000004);

        // Single frame 0xA5, checked cycle by cycle
        a5 = 8'hA5;
        sb.push_back(a5);
        store(BASE, 32'h000000A5);
        load(BASE + 32'd4, 1'b1, v);
        check32("status_after_push", v, 32'h00000100);
        check32("tx_before_start", {31'b0, tx}, 32'd1);
        @(posedge clock);
        #1;
        errs = 0;
        first_bad = -1;
        for (int k = 0; k < 40; k++) begin
            if (k < 4)       exp_tx = 1'b0;
            else if (k < 36) exp_tx = a5[(k - 4) / 4];
            else             exp_tx = 1'b1;
            if (tx !== exp_tx) begin
                errs++;
                if (first_bad < 0) first_bad = k;
            end
            if (k == 20) begin
                load(BASE + 32'd4, 1'b1, v);
                // FIFO already drained into the shifter: busy and empty
                check32("status_mid_frame", v, 32'h00000005);
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL frame_a5_timing: got %0d bad cycles (first %0d) expected 0", errs, first_bad);
        end
        load(BASE + 32'd4, 1'b1, v);
        check32("status_after_stop", v, 32'h00000004);

        // Burst of five stores, sixth overflows
        for (int i = 0; i < 5; i++) begin
            sb.push_back(8'h11 + 8'(i));
            store(BASE, 32'h11 + 32'(i));
        end
        store(BASE, 32'h16);
        load(BASE + 32'd4, 1'b1, v);
        check32("status_overflow", v, 32'h0000040B);
        store(BASE + 32'd4, 32'h8);
        load(BASE + 32'd4, 1'b1, v);
        check32("status_ovf_cleared", v, 32'h00000403);
        repeat (5 * 10 * CPB + 20) @(posedge clock);
        #1;
        load(BASE + 32'd4, 1'b1, v);
        check32("status_burst_done", v, 32'h00000004);
        check32("sb_burst_drained", 32'(sb.size()), 32'd0);

        // Reset during DATA bit 3 (0x53 has bit3 = 0); second byte queued
        sb.push_back(8'h53);
        store(BASE, 32'h53);
        store(BASE, 32'h5A);
        repeat (16) @(posedge clock);
        #1;
        check32("tx_bit3_before_reset", {31'b0, tx}, 32'd0);
        sb.delete();
        reset = 1'b1;
        @(posedge clock);
        #1;
        check32("tx_after_reset", {31'b0, tx}, 32'd1);
        reset = 1'b0;
        load(BASE + 32'd4, 1'b1, v);
        check32("status_after_reset", v, 32'h00000004);
        repeat (100) @(posedge clock);
        #1;
        check32("tx_no_frames_after_reset", {31'b0, tx}, 32'd1);

        // Unmapped / ignored accesses
        store(BASE + 32'd8, 32'h77);
        store(32'h10010000, 32'h66);
        load(BASE + 32'd4, 1'b1, v);
        check32("status_no_push", v, 32'h00000004);
        load(32'h10010000, 1'b1, v);
        check32("read_unselected", v, 32'h00000000);
        load(BASE, 1'b1, v);
        check32("read_txdata", v, 32'h00000000);
        load(BASE + 32'd4, 1'b0, v);
        check32("read_no_memread", v, 32'h00000000);
        repeat (60) @(posedge clock);
        #1;
        check32("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
